// File: rtl/load_store_unit_pkg.sv
// Shared constants and types for the RV32I load/store unit: opcodes,
// funct3 width codes, FSM state encoding and the captured-request context.
package load_store_unit_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // S_SKIP holds a no-op/faulting access for one cycle so its response
  // lands on the same cycle as the fastest possible memory access.
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_SKIP,
    S_RESP
  } lsu_state_t;

  typedef struct packed {
    logic       is_load;
    logic [2:0] funct3;
    logic [1:0] byte_off;
    logic       misaligned;
    logic       illegal;
  } lsu_ctx_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request/response and data-memory port of the load/store unit.
// master = the LSU itself, slave = its environment (execute stage + memory).
interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata_out;
  logic        misaligned;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, opcode, funct3, addr, wdata, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, rdata_out, misaligned, bus_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output req_valid, opcode, funct3, addr, wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, rdata_out, misaligned, bus_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication/strobes, load extraction with
// sign/zero extension, and misaligned/illegal access decode.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_byte_off,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_ldata,
  output logic        o_misaligned,
  output logic        o_illegal
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_byte_off, 3'b000};

  always_comb begin
    o_wdata = i_wdata;
    o_wstrb = 4'b1111;
    case (i_funct3[1:0])
      2'b00: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_wstrb = 4'b0001 << i_byte_off;
      end
      2'b01: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_wstrb = i_byte_off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ldata = 32'h0;
    case (i_funct3)
      F3_B:    o_ldata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_ldata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_ldata = w_shifted;
      F3_BU:   o_ldata = {24'h0, w_shifted[7:0]};
      F3_HU:   o_ldata = {16'h0, w_shifted[15:0]};
      default: o_ldata = 32'h0;
    endcase
  end

  // An illegal width is reported alone; alignment is only judged for legal widths.
  always_comb begin
    o_illegal = 1'b0;
    if (i_is_load)
      o_illegal = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
    else if (i_is_store)
      o_illegal = (i_funct3 > F3_W);
    o_misaligned = (i_is_load || i_is_store) && !o_illegal &&
                   (((i_funct3[1:0] == 2'b01) && i_byte_off[0]) ||
                    ((i_funct3 == F3_W) && (i_byte_off != 2'b00)));
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one access from execute, drives a single
// req/gnt + rvalid data-memory port, and returns one response pulse.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.master bus
);

  localparam logic [15:0] LP_LAST = 16'(TIMEOUT - 1);

  lsu_state_t  r_state;
  lsu_ctx_t    r_ctx;
  logic [15:0] r_cnt;
  logic        r_ready;
  logic        r_resp_valid;
  logic [31:0] r_rdata;
  logic        r_misaligned;
  logic        r_bus_err;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_accept;
  logic        w_timeout;
  logic [2:0]  w_funct3;
  logic [1:0]  w_byte_off;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_ldata;
  logic        w_misaligned;
  logic        w_illegal;

  assign w_is_load  = (bus.opcode == OP_LOAD);
  assign w_is_store = (bus.opcode == OP_STORE);
  assign w_accept   = bus.req_valid && r_ready;
  assign w_timeout  = (r_cnt == LP_LAST);

  // Decode works on live inputs while idle, extraction on the captured context.
  assign w_funct3   = (r_state == S_IDLE) ? bus.funct3    : r_ctx.funct3;
  assign w_byte_off = (r_state == S_IDLE) ? bus.addr[1:0] : r_ctx.byte_off;

  lsu_align u_align (
    .i_funct3     (w_funct3),
    .i_byte_off   (w_byte_off),
    .i_is_load    (w_is_load),
    .i_is_store   (w_is_store),
    .i_wdata      (bus.wdata),
    .i_rdata      (bus.mem_rdata),
    .o_wdata      (w_wdata),
    .o_wstrb      (w_wstrb),
    .o_ldata      (w_ldata),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ctx        <= '0;
      r_cnt        <= 16'h0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'h0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_mem_wstrb  <= 4'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_ctx   <= '{is_load: w_is_load, funct3: bus.funct3, byte_off: bus.addr[1:0],
                         misaligned: w_misaligned, illegal: w_illegal};
            if ((w_is_load || w_is_store) && !w_misaligned && !w_illegal) begin
              r_state     <= S_REQ;
              r_cnt       <= 16'h0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_is_store;
              r_mem_addr  <= {bus.addr[31:2], 2'b00};
              r_mem_wdata <= w_is_store ? w_wdata : 32'h0;
              r_mem_wstrb <= w_is_store ? w_wstrb : 4'h0;
            end else begin
              r_state <= S_SKIP;
            end
          end
        end
        S_REQ: begin
          if (w_timeout || bus.mem_gnt) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_wstrb <= 4'h0;
          end
          if (w_timeout) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_bus_err    <= 1'b1;
          end else if (bus.mem_gnt) begin
            if (r_ctx.is_load) begin
              r_state <= S_WAIT_R;
              r_cnt   <= 16'h0;
            end else begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'h1;
          end
        end
        S_WAIT_R: begin
          if (w_timeout) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_bus_err    <= 1'b1;
          end else if (bus.mem_rvalid) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_rdata      <= w_ldata;
          end else begin
            r_cnt <= r_cnt + 16'h1;
          end
        end
        S_SKIP: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_misaligned <= r_ctx.misaligned;
          r_bus_err    <= r_ctx.illegal;
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_ready      <= 1'b1;
          r_resp_valid <= 1'b0;
          r_rdata      <= 32'h0;
          r_misaligned <= 1'b0;
          r_bus_err    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.rdata_out  = r_rdata;
  assign bus.misaligned = r_misaligned;
  assign bus.bus_err    = r_bus_err;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_wstrb  = r_mem_wstrb;

endmodule
